// File: rtl/mdu_pkg.sv
// Shared op encodings and default latencies for the multiply/divide unit.
package mdu_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned CNT_W       = 5;
  localparam int unsigned MUL_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF = 10;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } mdu_op_e;

endpackage

// File: rtl/mdu_div_core.sv
// Combinational signed/unsigned 32-bit divider.
// Quotient truncates toward zero; remainder takes the sign of the dividend.
module mdu_div_core
  import mdu_pkg::*;
(
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            is_signed,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            div_by_zero
);

  logic            neg_a;
  logic            neg_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [XLEN-1:0] safe_b;
  logic [XLEN-1:0] q_u;
  logic [XLEN-1:0] r_u;

  // Divide magnitudes, then restore signs; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  always_comb begin
    neg_a       = is_signed & dividend[XLEN-1];
    neg_b       = is_signed & divisor[XLEN-1];
    mag_a       = neg_a ? -dividend : dividend;
    mag_b       = neg_b ? -divisor : divisor;
    div_by_zero = (divisor == '0);
    safe_b      = div_by_zero ? XLEN'(1) : mag_b;
    q_u         = mag_a / safe_b;
    r_u         = mag_a % safe_b;
    quotient    = (neg_a ^ neg_b) ? -q_u : q_u;
    remainder   = neg_a ? -r_u : r_u;
  end

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] pend_q, pend_d;
  logic              pend_wr_q, pend_wr_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              busy_q, busy_d;

  logic [2*XLEN-1:0] prod_s;
  logic [2*XLEN-1:0] prod_u;
  logic [XLEN-1:0]   div_q;
  logic [XLEN-1:0]   div_r;
  logic              div_zero;

  mdu_div_core u_div (
    .dividend    (a),
    .divisor     (b),
    .is_signed   (op == OP_DIV),
    .quotient    (div_q),
    .remainder   (div_r),
    .div_by_zero (div_zero)
  );

  // Low 64 bits of the sign/zero-extended product are the exact 32x32 result.
  always_comb begin
    prod_s = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{b[XLEN-1]}}, b};
    prod_u = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
  end

  always_comb begin
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1) && pend_wr_q) begin
        hi_d = pend_q[2*XLEN-1:XLEN];
        lo_d = pend_q[XLEN-1:0];
      end
    end else if (start) begin
      case (op)
        OP_MULT: begin
          pend_d    = prod_s;
          pend_wr_d = 1'b1;
          cnt_d     = CNT_W'(MUL_LAT);
        end
        OP_MULTU: begin
          pend_d    = prod_u;
          pend_wr_d = 1'b1;
          cnt_d     = CNT_W'(MUL_LAT);
        end
        OP_DIV, OP_DIVU: begin
          pend_d    = {div_r, div_q};
          pend_wr_d = ~div_zero;
          cnt_d     = CNT_W'(DIV_LAT);
        end
        OP_MTHI: hi_d = a;
        OP_MTLO: lo_d = a;
`ifdef MDU_MADD_EN
        OP_MADD: begin
          pend_d    = {hi_q, lo_q} + prod_s;
          pend_wr_d = 1'b1;
          cnt_d     = CNT_W'(MUL_LAT);
        end
        OP_MADDU: begin
          pend_d    = {hi_q, lo_q} + prod_u;
          pend_wr_d = 1'b1;
          cnt_d     = CNT_W'(MUL_LAT);
        end
        OP_MSUB: begin
          pend_d    = {hi_q, lo_q} - prod_s;
          pend_wr_d = 1'b1;
          cnt_d     = CNT_W'(MUL_LAT);
        end
        OP_MSUBU: begin
          pend_d    = {hi_q, lo_q} - prod_u;
          pend_wr_d = 1'b1;
          cnt_d     = CNT_W'(MUL_LAT);
        end
`else
`endif
        default: ;
      endcase
    end

    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      pend_q    <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: directed plan vectors plus randomized ops vs. an arithmetic model.
module tb_mdu_hilo;
  import mdu_pkg::*;

  localparam int unsigned MUL_LAT = MUL_LAT_DEF;
  localparam int unsigned DIV_LAT = DIV_LAT_DEF;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb_q[$];
  int          checks;
  int          failures;
  bit          mon_en;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_hilo #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: architectural result of one accepted op on the current model HI/LO.
  task automatic model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output logic [31:0] nh, output logic [31:0] nl);
    longint          p;
    longint          q;
    longint          r;
    longint unsigned acc;
    lat = 0;
    nh  = m_hi;
    nl  = m_lo;
    acc = {m_hi, m_lo};
    case (o)
      OP_MULT:  begin lat = MUL_LAT; p = longint'(int'(x)) * longint'(int'(y)); {nh, nl} = p; end
      OP_MULTU: begin lat = MUL_LAT; p = longint'({32'd0, x}) * longint'({32'd0, y}); {nh, nl} = p; end
      OP_DIV: begin
        lat = DIV_LAT;
        if (y != 0) begin
          q  = longint'(int'(x)) / longint'(int'(y));
          r  = longint'(int'(x)) % longint'(int'(y));
          nl = q[31:0];
          nh = r[31:0];
        end
      end
      OP_DIVU: begin
        lat = DIV_LAT;
        if (y != 0) begin
          nl = x / y;
          nh = x % y;
        end
      end
      OP_MTHI: nh = x;
      OP_MTLO: nl = x;
`ifdef MDU_MADD_EN
      OP_MADD:  begin lat = MUL_LAT; p = longint'(int'(x)) * longint'(int'(y)); {nh, nl} = acc + p; end
      OP_MADDU: begin lat = MUL_LAT; p = longint'({32'd0, x}) * longint'({32'd0, y}); {nh, nl} = acc + p; end
      OP_MSUB:  begin lat = MUL_LAT; p = longint'(int'(x)) * longint'(int'(y)); {nh, nl} = acc - p; end
      OP_MSUBU: begin lat = MUL_LAT; p = longint'({32'd0, x}) * longint'({32'd0, y}); {nh, nl} = acc - p; end
`else
`endif
      default: ;
    endcase
  endtask

  // Push expectation, drive one accepted op, optionally pulse start while busy, then let it drain.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int lat, input logic [31:0] nh, input logic [31:0] nl, input bit pulse);
    exp_t e;
    e.lat = lat;
    e.hi  = nh;
    e.lo  = nl;
    sb_q.push_back(e);
    m_hi = nh;
    m_lo = nl;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    for (int k = 2; k <= lat + 2; k++) begin
      @(negedge clk);
      start = pulse && (k <= lat) && ((k % 3 == 1) || (k == lat));
      op    = 4'($urandom_range(1, 6));
      a     = $urandom;
      b     = $urandom;
    end
    start = 1'b0;
  endtask

  task automatic issue_model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int          lat;
    logic [31:0] nh;
    logic [31:0] nl;
    model(o, x, y, lat, nh, nl);
    issue(o, x, y, lat, nh, nl, 1'b0);
  endtask

  // Monitor: detects accepts at the interface and checks busy window and final HI/LO.
  initial begin
    bit   active;
    int   el;
    exp_t cur;
    logic busy_prev;
    active    = 1'b0;
    el        = 0;
    busy_prev = 1'b0;
    cur.lat   = 0;
    cur.hi    = '0;
    cur.lo    = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!mon_en || reset) begin
        active = 1'b0;
      end else begin
        if (!active && start && !busy_prev) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL accept actual=unexpected required=none at %0t", $time);
          end else begin
            cur    = sb_q.pop_front();
            active = 1'b1;
            el     = 0;
          end
        end
        if (active) begin
          el++;
          if (el <= cur.lat) begin
            chk("busy_high", 64'(busy), 64'd1);
          end else begin
            chk("busy_low", 64'(busy), 64'd0);
            chk("hi", 64'(hi), 64'(cur.hi));
            chk("lo", 64'(lo), 64'(cur.lo));
            active = 1'b0;
          end
        end
      end
      busy_prev = busy;
    end
  end

  initial begin
    logic [3:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    checks   = 0;
    failures = 0;
    mon_en   = 1'b0;
    reset    = 1'b1;
    start    = 1'b0;
    op       = '0;
    a        = '0;
    b        = '0;
    m_hi     = '0;
    m_lo     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    issue(OP_MULT,  32'hFFFFFFFE, 32'd3,        MUL_LAT, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    issue(OP_DIV,   32'hFFFFFFF9, 32'd2,        DIV_LAT, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    issue(OP_MTHI,  32'h11,       32'd0,        0,       32'h11,       32'hFFFFFFFD, 1'b0);
    issue(OP_MTLO,  32'h22,       32'd0,        0,       32'h11,       32'h22,       1'b0);
    issue(OP_DIVU,  32'd100,      32'd0,        DIV_LAT, 32'h11,       32'h22,       1'b0);
    issue(OP_MTLO,  32'h1234,     32'd7,        0,       32'h11,       32'h1234,     1'b0);
    issue(OP_DIV,   32'h80000000, 32'hFFFFFFFF, DIV_LAT, 32'h0,        32'h80000000, 1'b1);
    issue(OP_NONE,  32'h5555,     32'h6666,     0,       32'h0,        32'h80000000, 1'b0);
    issue(4'd15,    32'h5555,     32'h6666,     0,       32'h0,        32'h80000000, 1'b0);
    issue(OP_DIVU,  32'd100,      32'd7,        DIV_LAT, 32'd2,        32'd14,       1'b1);

    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(0, 15));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 4))
        0:       y = '0;
        1:       y = 32'($urandom_range(1, 9));
        2:       begin x = 32'h80000000; y = 32'hFFFFFFFF; end
        default: ;
      endcase
      issue_model(o, x, y);
    end

    issue(OP_MTHI, 32'hDEAD, 32'd0, 0, 32'hDEAD, m_lo, 1'b0);
    issue(OP_MTLO, 32'hBEEF, 32'd0, 0, 32'hDEAD, 32'hBEEF, 1'b0);

    // Abort a MULT with reset during its third busy cycle.
    mon_en = 1'b0;
    @(negedge clk);
    start = 1'b1;
    op    = OP_MULT;
    a     = 32'd1234;
    b     = 32'd5678;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (MUL_LAT + 3) begin
      @(posedge clk);
      #1;
      chk("post_abort", {31'd0, busy, hi}, 64'd0);
      chk("post_abort_lo", 64'(lo), 64'd0);
    end
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    mon_en = 1'b1;
    issue_model(OP_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF);

    repeat (2) @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers, in the EX stage beside the ALU.
- Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO using EX-stage forwarded operands (rs, rt).
- Asserts busy so the D-stage stall logic can hold MFHI/MFLO and any further MDU ops.
- Replaces the ALU's combinational lo/hi path; MFHI/MFLO read hi/lo directly.

Parameters:
- MUL_LAT, 5, busy cycles for MULT/MULTU (valid range 1..31).
- DIV_LAT, 10, busy cycles for DIV/DIVU (valid range 1..31).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- start  in  1  EX-stage instruction is an MDU op, qualified by the EX-stage work flag.
- op  in  4  operation code; encodings defined in mdu_pkg.
- a  in  32  rs operand, already forwarded.
- b  in  32  rt operand, already forwarded.
- busy  out  1  high while an operation is in flight.
- hi  out  32  architectural HI register.
- lo  out  32  architectural LO register.

Behaviour:
- Reset: busy=0, hi=0, lo=0, counter=0, pending result=0.
- Reset mid-operation: aborts the op; hi/lo become 0 and the pending result is discarded.
- Accept rule: op is accepted in cycle T when start=1 and busy=0. start while busy=1 is ignored; stall logic guarantees this does not happen.
- MULT/MULTU, DIV/DIVU:
  - At T, latch the 64-bit result into pending and load counter with MUL_LAT or DIV_LAT.
  - busy = (counter != 0). busy is high in cycles T+1 .. T+LAT.
  - Counter decrements each cycle.
  - On the edge where counter goes 1->0, hi/lo take the pending value.
  - The new hi/lo are visible at T+LAT+1, the same cycle busy falls.
- MTHI/MTLO:
  - At T, hi<=a or lo<=a respectively; visible at T+1.
  - busy stays 0; the other register is unchanged.
- MULT: signed 32x32 -> 64; {hi,lo} = a*b.
- MULTU: unsigned 32x32 -> 64.
- DIV (signed):
  - lo = quotient truncated toward zero; hi = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned; lo = quotient, hi = remainder.
- Divide by zero:
  - Full DIV_LAT busy period still occurs.
  - At completion hi and lo are left unchanged, i.e. the result is discarded.
- op NONE or an undefined code with start=1: no effect, busy stays 0.
- hi/lo hold their value between operations; they never change while busy=1.

Optional Feature:
- Macro MDU_MADD_EN.
- When defined: adds MADD, MADDU, MSUB, MSUBU.
  - MADD: {hi,lo} <= {hi,lo} + product (64-bit, wraps modulo 2^64).
  - MSUB: {hi,lo} <= {hi,lo} - product (64-bit, wraps modulo 2^64).
  - The product is signed for MADD/MSUB and unsigned for MADDU/MSUBU.
  - The accumulate uses hi/lo as sampled at accept time T; latency is MUL_LAT.
- When undefined: these four codes behave as undefined (no effect, busy stays 0).

Decomposition:
- mdu_pkg holds the op encodings:
  - NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10.
  - Also holds the default latency constants.
- The controller decodes the instruction into these codes.
- One sub-module, mdu_div_core: combinational signed/unsigned divide.
  - Outputs quotient, remainder and div_by_zero.
  - Owns the sign-correction rules and the overflow case.
- Counter, pending register and HI/LO update logic stay in mdu_hilo.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3 at T:
  - busy=1 for T+1..T+5.
  - At T+6: busy=0, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF:
  - At T+MUL_LAT+1: hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7 (0xFFFFFFF9), b=2:
  - After 10 busy cycles: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU a=100, b=0 after hi=0x11, lo=0x22:
  - busy lasts 10 cycles.
  - hi=0x11 and lo=0x22 remain unchanged.
- MTLO a=0x1234 with start=1:
  - Next cycle lo=0x1234, busy=0, hi unchanged.
  - start pulses while busy=1 during a DIV leave the final DIV result unaffected.
- Reset asserted at T+3 of a MULT:
  - Next cycle busy=0, hi=0, lo=0.
  - No later update occurs.
